// File: rtl/neighbor_link_coalesce_fifo_if.sv
// Message bus between a neighbor link and the fabric.
// The outbound side is a FWFT stream toward node B. The inbound side carries
// node B's messages into the link. Both use {increase, root} payloads.
interface neighbor_link_coalesce_fifo_if #(
  parameter int ADDRESS_WIDTH = 12
);
  logic [ADDRESS_WIDTH:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDRESS_WIDTH:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  // The link itself: produces the outbound stream and sinks inbound messages.
  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  // The fabric side: consumes the outbound stream and drives inbound messages.
  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/neighbor_link_coalesce_fifo.sv
// Neighbor link with an outbound FWFT FIFO.
// Changes in node A's root/increase state become messages toward node B.
// When the FIFO is full, one holding register absorbs and merges updates so
// that no update is lost. The block also sinks node B's messages and tracks
// edge growth against a length that can be loaded at run time.
module neighbor_link_coalesce_fifo #(
  parameter int   ADDRESS_WIDTH = 12,
  parameter int   FIFO_DEPTH    = 16,
  parameter int   MAX_LENGTH    = 15,
  localparam int  LW            = $clog2(MAX_LENGTH + 1),
  localparam int  CW            = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     initialize,
  input  logic [LW-1:0]            length_in,
  output logic                     is_fully_grown,
  output logic [LW-1:0]            grown_count,
  input  logic [ADDRESS_WIDTH-1:0] a_old_root_in,
  input  logic                     a_increase,
  output logic [ADDRESS_WIDTH-1:0] b_old_root_out,
  output logic                     b_increase_out,
  neighbor_link_coalesce_fifo_if.master bus,
  output logic [CW-1:0]            fifo_level,
  output logic                     pending_valid,
  output logic                     coalesced
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [AW:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          coalesced_q, coalesced_d;
  logic [AW-1:0] last_root_q, last_root_d;
  logic          last_inc_q, last_inc_d;
  logic [AW-1:0] b_root_q, b_root_d;
  logic          b_inc_q, b_inc_d;
  logic [LW-1:0] grown_q, grown_d;
  logic [LW-1:0] len_q, len_d;

  logic          pop, full, space, ev, wr_en;
  logic [AW:0]   msg, wr_data;
  logic [LW:0]   grow_sum;

  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.in_ready   = 1'b1;
  assign fifo_level     = count_q;
  assign pending_valid  = pend_vld_q;
  assign coalesced      = coalesced_q;
  assign b_old_root_out = b_root_q;
  assign b_increase_out = b_inc_q;
  assign grown_count    = grown_q;
  assign is_fully_grown = (grown_q >= len_q);

  // Next-state: event detection, enqueue/coalesce priority, inbound sink, growth.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    coalesced_d = coalesced_q;
    last_root_d = last_root_q;
    last_inc_d  = last_inc_q;
    b_root_d    = b_root_q;
    b_inc_d     = b_inc_q;
    grown_d     = grown_q;
    len_d       = len_q;
    wr_en       = 1'b0;
    wr_data     = pend_q;

    msg      = {a_increase, a_old_root_in};
    pop      = bus.out_valid && bus.out_ready && !initialize;
    full     = (count_q == CW'(FIFO_DEPTH));
    space    = !full || pop;
    ev       = !initialize && ((a_old_root_in != last_root_q) || (a_increase != last_inc_q));
    grow_sum = {1'b0, grown_q} + {{LW{1'b0}}, a_increase} + {{LW{1'b0}}, b_inc_q};

    if (initialize) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      pend_d      = '0;
      pend_vld_d  = 1'b0;
      coalesced_d = 1'b0;
      last_root_d = '0;
      last_inc_d  = 1'b0;
      b_root_d    = '0;
      b_inc_d     = 1'b0;
      grown_d     = '0;
      len_d       = length_in;
    end else begin
      last_root_d = a_old_root_in;
      last_inc_d  = a_increase;

      // The pending entry is always older than a new event, so it drains first.
      if (pend_vld_q && space) begin
        wr_en      = 1'b1;
        wr_data    = pend_q;
        pend_vld_d = ev;
        if (ev) pend_d = msg;
      end else if (ev && space) begin
        wr_en   = 1'b1;
        wr_data = msg;
      end else if (ev) begin
        // No room: park the event, merging with an existing pending entry.
        if (pend_vld_q) begin
          pend_d      = {pend_q[AW] | a_increase, a_old_root_in};
          coalesced_d = 1'b1;
        end else begin
          pend_vld_d = 1'b1;
          pend_d     = msg;
        end
      end

      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);

      if (bus.in_valid) begin
        b_root_d = bus.in_data[AW-1:0];
        if (bus.in_data[AW]) b_inc_d = 1'b1;
      end

      // Growth saturates at the latched length; the registered b_inc counts every cycle.
      if (grown_q < len_q)
        grown_d = (grow_sum > {1'b0, len_q}) ? len_q : grow_sum[LW-1:0];
    end
  end

  // State registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      coalesced_q <= 1'b0;
      last_root_q <= '0;
      last_inc_q  <= 1'b0;
      b_root_q    <= '0;
      b_inc_q     <= 1'b0;
      grown_q     <= '0;
      len_q       <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      coalesced_q <= coalesced_d;
      last_root_q <= last_root_d;
      last_inc_q  <= last_inc_d;
      b_root_q    <= b_root_d;
      b_inc_q     <= b_inc_d;
      grown_q     <= grown_d;
      len_q       <= len_d;
    end
  end
endmodule

// File: tb/tb_neighbor_link_coalesce_fifo.sv
// Bench for neighbor_link_coalesce_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the link.
module tb_neighbor_link_coalesce_fifo;
  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int MAXL  = 15;
  localparam int LW    = $clog2(MAXL + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, initialize;
  logic [LW-1:0] length_in;
  logic          is_fully_grown;
  logic [LW-1:0] grown_count;
  logic [AW-1:0] a_old_root_in;
  logic          a_increase;
  logic [AW-1:0] b_old_root_out;
  logic          b_increase_out;
  logic [CW-1:0] fifo_level;
  logic          pending_valid, coalesced;

  neighbor_link_coalesce_fifo_if #(.ADDRESS_WIDTH(AW)) bus ();

  neighbor_link_coalesce_fifo #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_LENGTH(MAXL)) dut (
    .clk(clk), .reset(reset), .initialize(initialize), .length_in(length_in),
    .is_fully_grown(is_fully_grown), .grown_count(grown_count),
    .a_old_root_in(a_old_root_in), .a_increase(a_increase),
    .b_old_root_out(b_old_root_out), .b_increase_out(b_increase_out),
    .bus(bus), .fifo_level(fifo_level), .pending_valid(pending_valid), .coalesced(coalesced)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [AW:0]   mq[$];
  logic [AW:0]   m_pd;
  bit            m_pv, m_coal, m_binc, m_last_inc;
  logic [AW-1:0] m_broot, m_last_root;
  int            m_grown, m_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pd = '0; m_pv = 0; m_coal = 0; m_binc = 0; m_last_inc = 0;
    m_broot = '0; m_last_root = '0; m_grown = 0; m_len = 0;
  endtask

  // One clock of the link, from the inputs currently applied.
  task automatic model_step();
    bit ev, pop, space;
    logic [AW:0] msg;
    int sum;
    if (initialize) begin
      model_reset();
      m_len = int'(length_in);
      return;
    end
    msg   = {a_increase, a_old_root_in};
    ev    = (a_old_root_in != m_last_root) || (a_increase != m_last_inc);
    pop   = (mq.size() > 0) && bus.out_ready;
    space = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (m_pv && space) begin
      mq.push_back(m_pd);
      m_pv = ev;
      if (ev) m_pd = msg;
    end else if (ev && space) begin
      mq.push_back(msg);
    end else if (ev) begin
      if (m_pv) begin
        m_pd   = {m_pd[AW] | a_increase, a_old_root_in};
        m_coal = 1;
      end else begin
        m_pv = 1;
        m_pd = msg;
      end
    end
    if (m_grown < m_len) begin
      sum     = m_grown + int'(a_increase) + int'(m_binc);
      m_grown = (sum > m_len) ? m_len : sum;
    end
    if (bus.in_valid) begin
      m_broot = bus.in_data[AW-1:0];
      if (bus.in_data[AW]) m_binc = 1;
    end
    m_last_root = a_old_root_in;
    m_last_inc  = a_increase;
  endtask

  task automatic compare_all();
    chk("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0) chk("out_data", bus.out_data, mq[0]);
    chk("fifo_level", fifo_level, mq.size());
    chk("pending_valid", pending_valid, m_pv);
    chk("coalesced", coalesced, m_coal);
    chk("b_old_root", b_old_root_out, m_broot);
    chk("b_increase", b_increase_out, m_binc);
    chk("grown_count", grown_count, m_grown);
    chk("fully_grown", is_fully_grown, m_grown >= m_len);
    chk("in_ready", bus.in_ready, 1);
  endtask

  // Inputs are set shortly after a rising edge; the model advances, then the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [AW-1:0] root, input logic inc);
    a_old_root_in = root;
    a_increase    = inc;
    cyc();
  endtask

  task automatic do_init(input int len, input logic [AW-1:0] root);
    initialize = 1; length_in = LW'(len); a_old_root_in = root; a_increase = 0;
    cyc();
    initialize = 0;
  endtask

  task automatic async_reset();
    #2 reset = 1;
    #1 model_reset();
    compare_all();
    #1 reset = 0;
  endtask

  initial begin
    reset = 1; initialize = 0; length_in = '0; a_old_root_in = '0; a_increase = 0;
    bus.out_ready = 0; bus.in_valid = 0; bus.in_data = '0;
    model_reset();
    #3;
    compare_all();
    chk("rst_fully_grown", is_fully_grown, 1);
    @(posedge clk); #1;
    reset = 0;

    // First message appears one cycle after the change and is held until popped.
    do_init(4, 12'h005);
    cyc();
    chk("first_msg", bus.out_data, 13'h0005);
    chk("first_lvl", fifo_level, 1);
    repeat (3) cyc();
    chk("first_held", bus.out_valid, 1);
    bus.out_ready = 1; cyc();
    bus.out_ready = 0;

    // 17 changes with no consumer: 16 in the FIFO, one parked; drain in order.
    for (int r = 1; r <= 17; r++) drive(AW'(r), 0);
    chk("fill_lvl", fifo_level, 16);
    chk("fill_pend", pending_valid, 1);
    for (int i = 1; i <= 17; i++) begin
      chk("pop_seq", bus.out_data, i);
      bus.out_ready = 1;
      cyc();
    end
    chk("drained", bus.out_valid, 0);
    bus.out_ready = 0;

    // Merge while full: {1,0x00A} then {0,0x00B} must become {1,0x00B}.
    do_init(4, 12'h000);
    for (int r = 0; r < 16; r++) drive(AW'(12'h020 + r), 0);
    drive(12'h00A, 1);
    drive(12'h00B, 0);
    chk("merge_coal", coalesced, 1);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("merge_tail", bus.out_data, 13'h100B);
      bus.out_ready = 1;
      cyc();
    end
    bus.out_ready = 0;

    // Growth: A pulses once, B reports growth; count saturates at 4.
    do_init(4, 12'h000);
    bus.out_ready = 1;
    drive(12'h000, 1);
    a_increase = 0; bus.in_valid = 1; bus.in_data = 13'h1003;
    cyc();
    bus.in_valid = 0;
    repeat (6) cyc();
    chk("grow_cnt", grown_count, 4);
    chk("grow_full", is_fully_grown, 1);
    chk("grow_broot", b_old_root_out, 12'h003);
    chk("grow_binc", b_increase_out, 1);

    // Full FIFO with a streaming consumer: no parking, no coalescing.
    bus.out_ready = 0;
    do_init(8, 12'h000);
    for (int r = 1; r <= 16; r++) drive(AW'(12'h100 + r), 0);
    chk("stream_full", fifo_level, 16);
    bus.out_ready = 1;
    for (int r = 1; r <= 10; r++) begin
      drive(AW'(12'h200 + r), 0);
      chk("stream_lvl", fifo_level, 16);
      chk("stream_pend", pending_valid, 0);
    end

    // Asynchronous reset in the middle of a burst.
    bus.out_ready = 0;
    for (int r = 1; r <= 5; r++) drive(AW'(12'h300 + r), 1);
    async_reset();
    chk("areset_valid", bus.out_valid, 0);
    chk("areset_lvl", fifo_level, 0);

    // Random traffic, with occasional initialize and asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      initialize    = ($urandom_range(0, 59) == 0);
      length_in     = LW'($urandom_range(0, MAXL));
      if ($urandom_range(0, 1) == 0) a_old_root_in = AW'($urandom_range(0, 3));
      a_increase    = ($urandom_range(0, 3) == 0);
      bus.out_ready = ((i / 64) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      bus.in_valid  = ($urandom_range(0, 7) == 0);
      bus.in_data   = (AW + 1)'($urandom);
      cyc();
      if ($urandom_range(0, 399) == 0) async_reset();
    end
    initialize = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
